uart_rx: RTL and testbench

- Serial-to-byte receiver for the CPU's UART peripheral: 8N1, LSB first, idle-high line.
- Consumes the line driven by the team's UART transmitter (external loopback or the host) and presents received bytes on a valid/ready port to the MMIO/CPU side.
- Bit timing matches the transmitter's: one bit period = CLKS_PER_BIT+1 clk cycles.
- Holds one byte and flags framing errors and overruns.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side port of the UART receiver: valid/ready read channel
// plus the framing-error and overrun event pulses.
interface uart_rx_if;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] byte_out;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd_valid,
    output byte_out,
    output frame_err,
    output overrun,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  byte_out,
    input  frame_err,
    input  overrun,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line.
// Single holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 174,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_serial,
  uart_rx_if.master rd
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  localparam logic [7:0] CPB = 8'(CLKS_PER_BIT);
  localparam logic [7:0] HB  = 8'(HALF_BIT);

  logic       meta_q;
  logic       rx_s_q;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       valid_q, valid_d;
  logic [7:0] byte_q, byte_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;

  logic       cnt_zero;
  logic       deliver;
  logic       pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= rx_serial;
      rx_s_q <= meta_q;
    end
  end

  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HB;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = CPB;
          idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = CPB;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (rx_s_q) begin
          deliver = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        // A held-low line must not be decoded as a stream of 0x00 frames.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pop = valid_q & rd.rd_ready;

  always_comb begin
    valid_d = valid_q & ~pop;
    byte_d  = byte_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      if (valid_q && !rd.rd_ready) begin
        ovr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        byte_d  = shift_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      valid_q <= 1'b0;
      byte_q  <= 8'd0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rd.rd_valid  = valid_q;
  assign rd.byte_out  = byte_q;
  assign rd.frame_err = ferr_q;
  assign rd.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial stimulus, expected bytes queued
// at send time and popped by a monitor on each read handshake.
module tb_uart_rx;

  localparam int BIT = 175;

  logic clk;
  logic rst;
  logic rx_serial;

  uart_rx_if rd_if ();

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .rd       (rd_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int lat;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_serial = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_serial = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic measure(output int n);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rd_if.rd_valid) break;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rd_if.rd_ready = v;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_if.rd_valid && rd_if.rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_byte: got %02h expected none", rd_if.byte_out);
      end else begin
        chk("rx_byte", int'(rd_if.byte_out), int'(exp_q.pop_front()));
      end
    end
    if (!rst && (rd_if.frame_err || rd_if.overrun)) begin
      if (rd_if.frame_err) ferr_cnt++;
      if (rd_if.overrun) ovr_cnt++;
      chk("flags_exclusive",
          int'(rd_if.frame_err & rd_if.overrun), 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b66;
    b66 = 8'h66;
    rst = 1'b1;
    rx_serial = 1'b1;
    rd_if.rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", int'(rd_if.rd_valid), 0);
    chk("reset_byte", int'(rd_if.byte_out), 0);
    chk("reset_ferr", int'(rd_if.frame_err), 0);
    chk("reset_ovr", int'(rd_if.overrun), 0);

    // 2 sync cycles + 1663 to the stop sample + 1 to rd_valid
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      measure(lat);
    join
    chk("a5_latency", lat, 1666);
    repeat (50) @(negedge clk);
    chk("a5_ferr", ferr_cnt, 0);
    chk("a5_ovr", ovr_cnt, 0);

    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    rx_serial = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_valid", int'(rd_if.rd_valid), 0);
    chk("glitch_ferr", ferr_cnt, 0);

    send_frame(8'h3C, 1'b0);
    repeat (500) @(negedge clk);
    rx_serial = 1'b1;
    repeat (400) @(negedge clk);
    chk("break_ferr", ferr_cnt, 1);
    chk("break_valid", int'(rd_if.rd_valid), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (100) @(negedge clk);
    chk("after_break_ferr", ferr_cnt, 1);
    chk("after_break_q", exp_q.size(), 0);

    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (50) @(negedge clk);
    chk("ovr_byte", int'(rd_if.byte_out), 8'h11);
    chk("ovr_valid", int'(rd_if.rd_valid), 1);
    chk("ovr_cnt", ovr_cnt, 1);
    set_ready(1'b1);
    repeat (5) @(negedge clk);
    chk("ovr_drop_valid", int'(rd_if.rd_valid), 0);
    chk("ovr_q", exp_q.size(), 0);

    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    repeat (50) @(negedge clk);
    chk("stream_q", exp_q.size(), 0);
    chk("stream_ferr", ferr_cnt, 1);
    chk("stream_ovr", ovr_cnt, 1);

    rx_serial = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = b66[i];
      repeat (BIT) @(negedge clk);
    end
    rx_serial = b66[4];
    repeat (80) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    rx_serial = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(rd_if.rd_valid), 0);
    chk("rst_byte", int'(rd_if.byte_out), 0);
    chk("rst_ferr", int'(rd_if.frame_err), 0);
    chk("rst_ovr", int'(rd_if.overrun), 0);
    repeat (400) @(negedge clk);
    chk("rst_no_66", int'(rd_if.rd_valid), 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (50) @(negedge clk);
    chk("7e_q", exp_q.size(), 0);
    chk("7e_ferr", ferr_cnt, 1);
    chk("7e_ovr", ovr_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
